// File: rtl/div_unit_pkg.sv
// Shared decode constants for the EX-stage divider: ALU control codes and MIPS funct codes
// that select DIV/DIVU, plus the default datapath width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    // 5-bit ALU control codes emitted by the ALU-control decoder.
    localparam logic [4:0] DIV_CONTROL  = 5'b10100;
    localparam logic [4:0] DIVU_CONTROL = 5'b10101;

    // R-type funct field values.
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle on operand magnitudes,
// signs restored on the final step. Quotient feeds LO, remainder feeds HI.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dz;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // |INT_MIN| stays 0x8000_0000 as an unsigned magnitude, which is what makes overflow wrap cleanly.
    assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // Restoring step: the dividend register doubles as the quotient shift register.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all state updates see pre-edge values, like real flops.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dz    <= 1'b0;
        end else if (annul) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        if (b == '0) begin
                            r_quot  <= '1;
                            r_remo  <= a;
                            r_dz    <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_rem   <= '0;
                            r_neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r <= is_signed & a[WIDTH-1];
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quot  <= r_neg_q ? -w_quo_next : w_quo_next;
                        r_remo  <= r_neg_r ? -w_rem_next : w_rem_next;
                        r_dz    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign valid       = r_valid;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued when a divide is issued
// and compared when valid pulses; cycle numbers count from the edge that samples start.
module tb_div_unit;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    res_t sb[$];
    res_t last_exp;
    int   total = 0;
    int   bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .busy       (busy),
        .valid      (valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] da, input logic [31:0] db, input logic sg);
        res_t        res;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] rm;
        logic        nq;
        logic        nr;
        if (db == 32'd0) begin
            res.q  = 32'hFFFF_FFFF;
            res.r  = da;
            res.dz = 1'b1;
        end else begin
            nq = sg & (da[31] ^ db[31]);
            nr = sg & da[31];
            ma = (sg && da[31]) ? (32'd0 - da) : da;
            mb = (sg && db[31]) ? (32'd0 - db) : db;
            q  = ma / mb;
            rm = ma % mb;
            res.q  = nq ? (32'd0 - q) : q;
            res.r  = nr ? (32'd0 - rm) : rm;
            res.dz = 1'b0;
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge; on return the bench sits in cycle 1 of the operation.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic sg);
        a         = ia;
        b         = ib;
        is_signed = sg;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        sb.push_back(model(ia, ib, sg));
    endtask

    // Waits for valid (bounded), checks its cycle number, pops and compares the scoreboard.
    task automatic collect(input string name, input int cur_cyc, input int exp_cyc);
        int   cyc;
        res_t e;
        cyc = cur_cyc;
        while (valid !== 1'b1 && cyc < 80) begin
            tick();
            cyc++;
        end
        total++;
        if (valid !== 1'b1) begin
            $display("FAIL %s_timeout: valid not seen by cycle %0d", name, cyc);
            bad++;
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            total++;
            if (cyc != exp_cyc) begin
                $display("FAIL %s_latency: valid in cycle %0d, want %0d", name, cyc, exp_cyc);
                bad++;
            end
            total++;
            if (busy !== 1'b0) begin
                $display("FAIL %s_busy_at_valid: busy=%b want 0", name, busy);
                bad++;
            end
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_unexpected: valid with empty scoreboard", name);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                total++;
                if ({quotient, remainder, div_by_zero} !== e) begin
                    $display("FAIL %s_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                             name, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({busy, valid, div_by_zero} !== 3'b000) begin
            $display("FAIL reset_flags: busy=%b valid=%b dz=%b want 000", busy, valid, div_by_zero);
            bad++;
        end
        total++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            $display("FAIL reset_results: q=%h r=%h want 0 0", quotient, remainder);
            bad++;
        end
        last_exp = '0;
    endtask

    task automatic test_unsigned_timing();
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            total++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                $display("FAIL u100_7_cycle%0d: busy=%b valid=%b want 1 0", c, busy, valid);
                bad++;
            end
            tick();
        end
        collect("u100_7", 33, 33);
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            $display("FAIL u100_7_const: q=%0d r=%0d dz=%b want 14 2 0", quotient, remainder, div_by_zero);
            bad++;
        end
        tick();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL u100_7_after: valid=%b busy=%b want 0 0", valid, busy);
            bad++;
        end
    endtask

    task automatic test_signed();
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        collect("s_m7_2", 1, 33);
        total++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            $display("FAIL s_m7_2_const: q=%h r=%h want fffffffd ffffffff", quotient, remainder);
            bad++;
        end
        tick();
    endtask

    task automatic test_div_zero();
        issue(32'h1234, 32'd0, 1'b0);
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL div0_busy: busy=%b want 0", busy);
            bad++;
        end
        collect("div0", 1, 1);
        total++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234 || div_by_zero !== 1'b1) begin
            $display("FAIL div0_const: q=%h r=%h dz=%b want ffffffff 1234 1", quotient, remainder, div_by_zero);
            bad++;
        end
        tick();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL div0_cycle2: valid=%b busy=%b want 0 0", valid, busy);
            bad++;
        end
        issue(32'd50, 32'd5, 1'b0);
        collect("div0_restart", 1, 33);
        tick();
    endtask

    task automatic test_overflow();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        collect("s_ovf", 1, 33);
        total++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            $display("FAIL s_ovf_const: q=%h r=%h dz=%b want 80000000 0 0", quotient, remainder, div_by_zero);
            bad++;
        end
        tick();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        collect("u_max_1", 1, 33);
        total++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
            $display("FAIL u_max_1_const: q=%h r=%h want ffffffff 0", quotient, remainder);
            bad++;
        end
        tick();
    endtask

    task automatic test_annul();
        issue(32'd1000, 32'd3, 1'b0);
        for (int c = 1; c < 10; c++) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        void'(sb.pop_back());
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            $display("FAIL annul_cycle11: busy=%b valid=%b want 0 0", busy, valid);
            bad++;
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== last_exp) begin
            $display("FAIL annul_hold: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     quotient, remainder, div_by_zero, last_exp.q, last_exp.r, last_exp.dz);
            bad++;
        end
        issue(32'hFFFF_FC18, 32'd3, 1'b1);
        collect("annul_restart", 12, 44);
        tick();
        start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
        tick();
        start = 1'b0; annul = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                $display("FAIL annul_with_start: busy=%b valid=%b want 0 0", busy, valid);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 1; c < 5; c++) tick();
        start = 1'b1; a = 32'd81; b = 32'd9; is_signed = 1'b1;
        tick();
        start = 1'b0;
        collect("ignored_start", 6, 33);
        tick();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL ignored_start_idle: valid=%b busy=%b want 0 0", valid, busy);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        issue(32'd12345, 32'd67, 1'b0);
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        total++;
        if ({busy, valid, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            $display("FAIL reset_mid: busy=%b valid=%b dz=%b q=%h r=%h want all 0",
                     busy, valid, div_by_zero, quotient, remainder);
            bad++;
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (valid === 1'b1 || busy === 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            $display("FAIL reset_mid_quiet: activity=%b want 0", seen);
            bad++;
        end
        last_exp = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom();
            rb = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(1, 300)));
            if (i == 5) rb = 32'hFFFF_FFF0;
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs);
            collect($sformatf("b2b_%0d", i), 1, (rb == 32'd0) ? 1 : 33);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_timing();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
